// File: rtl/beehive_noc_pkg.sv
// beehive_noc_pkg: route encodings, header field widths and the input-stage FSM states
package beehive_noc_pkg;
  localparam int FINAL_ROUTE_W = 3;
  typedef enum logic [2:0] {
    R_N = 3'd0,
    R_E = 3'd1,
    R_S = 3'd2,
    R_W = 3'd3,
    R_P = 3'd4
  } route_t;
  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;
endpackage

// File: rtl/beehive_noc_credit_fifo.sv
// beehive_noc_credit_fifo: credit-sized flit FIFO with a sticky overflow flag
module beehive_noc_credit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 512
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic ovf_q, wr, rd;
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign rd       = pop & ~empty;
  // a pop in the same cycle frees the slot a full push needs
  assign wr       = push & (~full | rd);
  assign dout     = mem_q[rp_q];
  assign overflow = ovf_q;
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
      if (push & ~wr) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/beehive_dynamic_input_route_buf.sv
// beehive_dynamic_input_route_buf: input-port flit buffer with XY route decode and packet-hold FSM
module beehive_dynamic_input_route_buf
  import beehive_noc_pkg::*;
#(
  parameter int NOC_DATA_W      = 512,
  parameter int XY_COORD_W      = 8,
  parameter int CHIP_ID_W       = 14,
  parameter int MSG_PAYLOAD_LEN = 22,
  parameter int BUF_DEPTH       = 4,
  parameter int OFFCHIP_ROUTE   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOC_DATA_W-1:0] data_in,
  input  logic                  valid_in,
  output logic                  yummy_out,
  input  logic [XY_COORD_W-1:0] my_loc_x,
  input  logic [XY_COORD_W-1:0] my_loc_y,
  input  logic [CHIP_ID_W-1:0]  my_chip_id,
  output logic [NOC_DATA_W-1:0] data_out,
  output logic                  valid_out,
  output logic                  tail_out,
  output logic                  route_req_n_out,
  output logic                  route_req_e_out,
  output logic                  route_req_s_out,
  output logic                  route_req_w_out,
  output logic                  route_req_p_out,
  input  logic                  thanks_n_in,
  input  logic                  thanks_e_in,
  input  logic                  thanks_s_in,
  input  logic                  thanks_w_in,
  input  logic                  thanks_p_in,
  output logic                  overflow_err
);
  localparam int CHIP_LSB = NOC_DATA_W - CHIP_ID_W;
  localparam int X_LSB    = CHIP_LSB - XY_COORD_W;
  localparam int Y_LSB    = X_LSB - XY_COORD_W;
  localparam int LEN_LSB  = Y_LSB - FINAL_ROUTE_W - MSG_PAYLOAD_LEN;
  localparam route_t OFF_R = route_t'(3'(OFFCHIP_ROUTE));
  logic [NOC_DATA_W-1:0] head;
  logic empty, full, pop, yummy_q;
  logic [XY_COORD_W-1:0] dx, dy;
  logic [CHIP_ID_W-1:0] dchip;
  logic [MSG_PAYLOAD_LEN-1:0] hlen, cnt_q;
  logic [4:0] req, thv;
  route_t route_dec, route_q, cur;
  state_t state_q;
  beehive_noc_credit_fifo #(.DEPTH(BUF_DEPTH), .W(NOC_DATA_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (valid_in),
    .pop      (pop),
    .din      (data_in),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow_err)
  );
  assign dchip = head[CHIP_LSB +: CHIP_ID_W];
  assign dx    = head[X_LSB +: XY_COORD_W];
  assign dy    = head[Y_LSB +: XY_COORD_W];
  assign hlen  = head[LEN_LSB +: MSG_PAYLOAD_LEN];
  always_comb begin
    route_dec = (dchip != my_chip_id) ? OFF_R :
                (dx > my_loc_x) ? R_E :
                (dx < my_loc_x) ? R_W :
                (dy > my_loc_y) ? R_S :
                (dy < my_loc_y) ? R_N : R_P;
    cur = (state_q == BODY) ? route_q : route_dec;
    // a body in flight keeps its output claimed even while the FIFO runs dry
    req = (state_q == BODY || !empty) ? 5'(1) << cur : 5'd0;
    thv = {thanks_p_in, thanks_w_in, thanks_s_in, thanks_e_in, thanks_n_in};
    pop = !empty && thv[cur];
    tail_out = !empty && ((state_q == BODY) ? cnt_q == MSG_PAYLOAD_LEN'(1) : hlen == '0);
  end
  assign {route_req_p_out, route_req_w_out, route_req_s_out, route_req_e_out, route_req_n_out} = req;
  assign valid_out = ~empty;
  assign data_out  = head;
  assign yummy_out = yummy_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HDR;
      route_q <= R_N;
      cnt_q   <= '0;
      yummy_q <= 1'b0;
    end else begin
      yummy_q <= pop;
      if (pop && state_q == HDR && hlen != '0) begin
        state_q <= BODY;
        route_q <= route_dec;
        cnt_q   <= hlen;
      end else if (pop && state_q == BODY) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == MSG_PAYLOAD_LEN'(1)) state_q <= HDR;
      end
    end
  end
endmodule

// File: tb/tb_beehive_dynamic_input_route_buf.sv
// tb_beehive_dynamic_input_route_buf: directed and randomized checks against a queue-based packet model
module tb_beehive_dynamic_input_route_buf;
  localparam int W = 512;
  localparam int DEPTH = 4;
  localparam logic [4:0] TN = 5'b00001, TE = 5'b00010, TS = 5'b00100, TW = 5'b01000, TP = 5'b10000;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0;
  logic [W-1:0] data_in = '0, data_out;
  logic [7:0] my_x = 8'd2, my_y = 8'd3;
  logic [13:0] my_chip = 14'd7;
  logic [4:0] th = '0;
  logic yummy_out, valid_out, tail_out, overflow_err;
  logic rq_n, rq_e, rq_s, rq_w, rq_p;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] fq[$];
  logic [W-1:0] pend[$];
  bit in_body = 0, ey = 0, eovf = 0;
  int unsigned remain = 0;
  int route = 0;
  always #5 clk = ~clk;
  beehive_dynamic_input_route_buf dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .yummy_out(yummy_out),
    .my_loc_x(my_x), .my_loc_y(my_y), .my_chip_id(my_chip),
    .data_out(data_out), .valid_out(valid_out), .tail_out(tail_out),
    .route_req_n_out(rq_n), .route_req_e_out(rq_e), .route_req_s_out(rq_s),
    .route_req_w_out(rq_w), .route_req_p_out(rq_p),
    .thanks_n_in(th[0]), .thanks_e_in(th[1]), .thanks_s_in(th[2]),
    .thanks_w_in(th[3]), .thanks_p_in(th[4]), .overflow_err(overflow_err)
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [W-1:0] hdr(input int chip, input int x, input int y, input int len);
    logic [W-1:0] h = rnd();
    h[511 -: 14] = 14'(chip);
    h[497 -: 8] = 8'(x);
    h[489 -: 8] = 8'(y);
    h[478 -: 22] = 22'(len);
    return h;
  endfunction
  function automatic int unsigned flen(input logic [W-1:0] f);
    return int'(f[478 -: 22]);
  endfunction
  function automatic int dec(input logic [W-1:0] f);
    int x = int'(f[497 -: 8]), y = int'(f[489 -: 8]);
    if (f[511 -: 14] != my_chip) return 3;
    if (x > int'(my_x)) return 1;
    if (x < int'(my_x)) return 3;
    if (y > int'(my_y)) return 2;
    if (y < int'(my_y)) return 0;
    return 4;
  endfunction
  function automatic int cur();
    if (in_body) return route;
    return fq.size() > 0 ? dec(fq[0]) : -1;
  endfunction
  task automatic check_all();
    int c = cur();
    bit ne = fq.size() > 0;
    bit et = 0;
    if (ne) et = in_body ? (remain == 1) : (flen(fq[0]) == 0);
    chk("valid_out", valid_out, ne);
    if (ne) chk("data_out", data_out, fq[0]);
    chk("tail_out", tail_out, et);
    chk("route_req", {rq_p, rq_w, rq_s, rq_e, rq_n}, c < 0 ? 5'd0 : 5'd1 << c);
    chk("yummy_out", yummy_out, ey);
    chk("overflow_err", overflow_err, eovf);
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input logic [4:0] t, input logic r);
    int c;
    bit p;
    logic [W-1:0] f;
    @(negedge clk);
    reset = r; valid_in = v; data_in = d; th = t;
    #1 check_all();
    @(posedge clk);
    if (r) begin
      fq.delete(); in_body = 0; remain = 0; ey = 0; eovf = 0;
    end else begin
      c = cur();
      p = fq.size() > 0 && c >= 0 && t[c];
      if (p) begin
        f = fq.pop_front();
        if (!in_body) begin
          if (flen(f) != 0) begin in_body = 1; remain = flen(f); route = dec(f); end
        end else begin
          remain--;
          if (remain == 0) in_body = 0;
        end
      end
      if (v) begin
        if (fq.size() < DEPTH) fq.push_back(d);
        else eovf = 1;
      end
      ey = p;
    end
  endtask
  task automatic idle(input logic [4:0] t);
    step(1'b0, '0, t, 1'b0);
  endtask
  task automatic do_reset();
    step(1'b0, '0, '0, 1'b1);
  endtask
  initial begin
    do_reset();
    do_reset();
    idle('0);
    // local delivery
    step(1'b1, hdr(7, 2, 3, 0), '0, 1'b0);
    idle(TP);
    idle('0);
    // XY order: east first
    step(1'b1, hdr(7, 5, 1, 2), TE, 1'b0);
    step(1'b1, rnd(), TE, 1'b0);
    step(1'b1, rnd(), TE, 1'b0);
    repeat (3) idle(TE);
    // stall mid-packet
    step(1'b1, hdr(7, 5, 1, 3), TE, 1'b0);
    step(1'b1, rnd(), TE, 1'b0);
    repeat (4) idle(TE);
    step(1'b1, rnd(), TE, 1'b0);
    step(1'b1, rnd(), TE, 1'b0);
    repeat (2) idle(TE);
    // wrong thanks
    step(1'b1, hdr(7, 2, 5, 0), '0, 1'b0);
    repeat (2) idle(TN | TP);
    idle(TS);
    idle('0);
    // full FIFO, push+pop when full, then true overflow
    do_reset();
    repeat (4) step(1'b1, hdr(7, 2, 3, 0), '0, 1'b0);
    step(1'b1, hdr(7, 2, 3, 0), TP, 1'b0);
    idle('0);
    step(1'b1, hdr(7, 2, 3, 0), '0, 1'b0);
    repeat (3) idle('0);
    // off-chip, then reset in BODY
    do_reset();
    step(1'b1, hdr(9, 2, 3, 2), '0, 1'b0);
    step(1'b1, rnd(), TW, 1'b0);
    idle('0);
    step(1'b1, rnd(), TW, 1'b1);
    repeat (2) idle(TW);
    // maximum length must not wrap
    step(1'b1, hdr(7, 2, 3, 22'h3fffff), '0, 1'b0);
    repeat (4) step(1'b1, rnd(), TP, 1'b0);
    repeat (3) idle(TP);
    do_reset();
    // randomized packet traffic
    for (int i = 0; i < 3000; i++) begin
      bit r = ($urandom % 400) == 0;
      bit v;
      logic [W-1:0] d;
      if (pend.size() == 0) begin
        int len = $urandom_range(0, 3);
        pend.push_back(hdr(($urandom % 5 == 0) ? 8 : 7, $urandom_range(0, 5), $urandom_range(0, 5), len));
        for (int j = 0; j < len; j++) pend.push_back(rnd());
      end
      if (r) pend.delete();
      v = !r && pend.size() > 0 && fq.size() < DEPTH && ($urandom % 4 != 0);
      d = v ? pend.pop_front() : rnd();
      step(v, d, 5'($urandom), r);
    end
    idle('0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
